// File: rtl/cpu_oam_dma_ctrl_if.sv
// CPU-side trigger, CU grant/request and DMA-owned system bus signals of the OAM DMA controller.
`timescale 1ns / 1ps
interface cpu_oam_dma_ctrl_if;
    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic [7:0]  cpu_dout;
    logic        dma_gnt;
    logic [7:0]  bus_din;
    logic        dma_bflg;
    logic [7:0]  dma_by;
    logic        bus_own;
    logic [15:0] bus_addr;
    logic        bus_rw;
    logic [7:0]  bus_dout;

    modport master (
        input  cpu_addr, cpu_rw, cpu_dout, dma_gnt, bus_din,
        output dma_bflg, dma_by, bus_own, bus_addr, bus_rw, bus_dout
    );

    modport slave (
        output cpu_addr, cpu_rw, cpu_dout, dma_gnt, bus_din,
        input  dma_bflg, dma_by, bus_own, bus_addr, bus_rw, bus_dout
    );
endinterface

// File: rtl/cpu_oam_dma_ctrl.sv
// Sprite DMA: a CPU write to $4014 copies page {page,00..FF} into PPU OAM via $2004 while
// the CU grants the bus.
`timescale 1ns / 1ps
module cpu_oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input logic                DMA_phi2,
    input logic                DMA_RST,
    cpu_oam_dma_ctrl_if.master dmaIf
);
    typedef enum logic [2:0] {
        StIdle, StReq, StHalt, StAlign, StRd, StWr, StDone, StPause
    } dmaState_e;

    dmaState_e   stateQ, stateD, resumeQ, resumeD;
    logic [7:0]  pageQ, pageD, idxQ, idxD, dataQ, dataD;
    logic        cycOddQ;
    logic        trigger;
    logic        bflgQ, bflgD, ownQ, ownD, rwQ, rwD;
    logic [15:0] addrQ, addrD;

    always_comb begin
        stateD  = stateQ;
        resumeD = resumeQ;
        pageD   = pageQ;
        idxD    = idxQ;
        dataD   = dataQ;
        trigger = (dmaIf.cpu_addr == DMA_REG_ADDR) && !dmaIf.cpu_rw;

        // Losing the grant in any bus-owning or dummy state parks in StPause and
        // returns to the same state, so an interrupted read is simply repeated.
        case (stateQ)
            StIdle: begin
                if (trigger) begin
                    pageD  = dmaIf.cpu_dout;
                    idxD   = 8'h00;
                    stateD = StReq;
                end
            end
            StReq: begin
                if (dmaIf.dma_gnt) stateD = StHalt;
            end
            StHalt: begin
                if (!dmaIf.dma_gnt) begin
                    resumeD = StHalt;
                    stateD  = StPause;
                end else if (cycOddQ) begin
                    stateD = StAlign;
                end else begin
                    stateD = StRd;
                end
            end
            StAlign: begin
                if (!dmaIf.dma_gnt) begin
                    resumeD = StAlign;
                    stateD  = StPause;
                end else begin
                    stateD = StRd;
                end
            end
            StRd: begin
                if (!dmaIf.dma_gnt) begin
                    resumeD = StRd;
                    stateD  = StPause;
                end else begin
                    dataD  = dmaIf.bus_din;
                    stateD = StWr;
                end
            end
            StWr: begin
                if (!dmaIf.dma_gnt) begin
                    resumeD = StWr;
                    stateD  = StPause;
                end else if (idxQ == 8'hFF) begin
                    // Clear idx so dma_by reads FF again once the transfer is over.
                    idxD   = 8'h00;
                    stateD = StDone;
                end else begin
                    idxD   = idxQ + 8'h01;
                    stateD = StRd;
                end
            end
            StDone:  stateD = StIdle;
            StPause: begin
                if (dmaIf.dma_gnt) stateD = resumeQ;
            end
            default: stateD = StIdle;
        endcase

        // Outputs are registered from the next state so they line up with the state cycle.
        bflgD = (stateD == StIdle) || (stateD == StDone);
        ownD  = (stateD == StRd) || (stateD == StWr);
        rwD   = (stateD != StWr);
        if (stateD == StRd) begin
            addrD = {pageD, idxD};
        end else if (stateD == StWr) begin
            addrD = OAM_DATA_ADDR;
        end else begin
            addrD = 16'h0000;
        end
    end

    always_ff @(posedge DMA_phi2 or posedge DMA_RST) begin
        if (DMA_RST) begin
            stateQ  <= StIdle;
            resumeQ <= StIdle;
            pageQ   <= 8'h00;
            idxQ    <= 8'h00;
            dataQ   <= 8'h00;
            cycOddQ <= 1'b0;
            bflgQ   <= 1'b1;
            ownQ    <= 1'b0;
            rwQ     <= 1'b1;
            addrQ   <= 16'h0000;
        end else begin
            stateQ  <= stateD;
            resumeQ <= resumeD;
            pageQ   <= pageD;
            idxQ    <= idxD;
            dataQ   <= dataD;
            cycOddQ <= ~cycOddQ;
            bflgQ   <= bflgD;
            ownQ    <= ownD;
            rwQ     <= rwD;
            addrQ   <= addrD;
        end
    end

    assign dmaIf.dma_bflg = bflgQ;
    assign dmaIf.dma_by   = 8'hFF - idxQ;
    assign dmaIf.bus_own  = ownQ;
    assign dmaIf.bus_addr = addrQ;
    assign dmaIf.bus_rw   = rwQ;
    assign dmaIf.bus_dout = dataQ;
endmodule

// File: tb/tb_cpu_oam_dma_ctrl.sv
// Bench for cpu_oam_dma_ctrl: transaction-level model of the 256-byte copy checked every cycle.
`timescale 1ns / 1ps
module tb_cpu_oam_dma_ctrl;
    logic clk;
    logic DMA_RST;
    cpu_oam_dma_ctrl_if bus ();

    cpu_oam_dma_ctrl dut (
        .DMA_phi2 (clk),
        .DMA_RST  (DMA_RST),
        .dmaIf    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [7:0] memf(input logic [15:0] a);
        return (a[7:0] * 8'd7) ^ a[15:8] ^ 8'h3C;
    endfunction

    assign bus.bus_din = (bus.bus_own && bus.bus_rw) ? memf(bus.bus_addr) : 8'hEE;

    // Model state: where the copy should be, independent of how the controller sequences it.
    int         cycNum    = 0;
    bit         mBusy     = 0;
    bit         mReq      = 0;
    bit         mWait     = 0;
    bit         doneFlag  = 0;
    bit         firstSeen = 0;
    logic [7:0] mPage     = 8'h00;
    int         nextIdx   = 0;
    bit         nextWr    = 0;
    int         haltCyc   = 0;
    int         lastSpan  = 0;
    int         expPen    = 0;

    always @(negedge clk) begin
        if (DMA_RST) begin
            cycNum   = 0;
            mBusy    = 0;
            mReq     = 0;
            mWait    = 0;
            doneFlag = 0;
            nextIdx  = 0;
            nextWr   = 0;
        end else begin
            bit wasDone;
            wasDone = doneFlag;
            chk("bflg", bus.dma_bflg, !mReq);
            chk("dma_by", bus.dma_by, (mBusy && !doneFlag) ? 8'(255 - nextIdx) : 8'hFF);
            if (!mReq) chk("own_idle", bus.bus_own, 1'b0);
            if (mWait && bus.dma_gnt) begin
                haltCyc = cycNum + 1;
                mWait   = 0;
            end
            if (bus.bus_own) begin
                if (!firstSeen) begin
                    firstSeen = 1;
                    chk("first_rd_delay", cycNum - haltCyc, 1 + haltCyc % 2);
                end
                chk("rw", bus.bus_rw, !nextWr);
                chk("addr", bus.bus_addr, nextWr ? 16'h2004 : {mPage, 8'(nextIdx)});
                if (nextWr) chk("wdata", bus.bus_dout, memf({mPage, 8'(nextIdx)}));
                if (bus.dma_gnt) begin
                    if (nextWr) begin
                        if (nextIdx == 255) begin
                            lastSpan = cycNum - haltCyc + 1;
                            chk("span_model", lastSpan, 513 + haltCyc % 2 + expPen);
                            mReq     = 0;
                            doneFlag = 1;
                            nextIdx  = 0;
                        end else begin
                            nextIdx++;
                        end
                    end
                    nextWr = !nextWr;
                end
            end
            if (bus.cpu_addr == 16'h4014 && !bus.cpu_rw && !mBusy) begin
                mBusy     = 1;
                mReq      = 1;
                mWait     = 1;
                firstSeen = 0;
                mPage     = bus.cpu_dout;
                nextIdx   = 0;
                nextWr    = 0;
                lastSpan  = 0;
            end
            if (wasDone) begin
                doneFlag = 0;
                mBusy    = 0;
            end
            cycNum++;
        end
    end

    task automatic checkResetValues(input string tag);
        chk({tag, "_own"}, bus.bus_own, 1'b0);
        chk({tag, "_bflg"}, bus.dma_bflg, 1'b1);
        chk({tag, "_by"}, bus.dma_by, 8'hFF);
        chk({tag, "_addr"}, bus.bus_addr, 16'h0000);
        chk({tag, "_rw"}, bus.bus_rw, 1'b1);
        chk({tag, "_dout"}, bus.bus_dout, 8'h00);
    endtask

    task automatic doXfer(input logic [7:0] pg, input bit oddPar, input int pauseIdx,
                          input int retrigIdx, input int rstIdx, input int pen);
        int zc;
        bit done;
        expPen = pen;
        @(posedge clk); #1;
        while ((cycNum % 2) != int'(oddPar)) begin
            @(posedge clk); #1;
        end
        bus.cpu_addr = 16'h4014;
        bus.cpu_rw   = 1'b0;
        bus.cpu_dout = pg;
        @(posedge clk); #1;
        bus.cpu_addr = 16'h0000;
        bus.cpu_rw   = 1'b1;
        bus.cpu_dout = 8'h00;
        bus.dma_gnt  = 1'b1;
        done = 0;
        for (int i = 0; i < 1200 && !done; i++) begin
            @(posedge clk); #1;
            if (bus.dma_bflg) begin
                done = 1;
            end else if (bus.bus_own && bus.bus_rw) begin
                if (pauseIdx >= 0 && bus.bus_addr == {pg, 8'(pauseIdx)}) begin
                    bus.dma_gnt = 1'b0;
                    zc = 0;
                    repeat (3) begin
                        @(posedge clk); #1;
                        if (!bus.bus_own) zc++;
                    end
                    bus.dma_gnt = 1'b1;
                    chk("pause_idle_cycles", zc, 3);
                    @(posedge clk); #1;
                    chk("pause_reread_own", bus.bus_own, 1'b1);
                    chk("pause_reread_addr", bus.bus_addr, {pg, 8'(pauseIdx)});
                    pauseIdx = -1;
                end else if (retrigIdx >= 0 && bus.bus_addr == {pg, 8'(retrigIdx)}) begin
                    bus.cpu_addr = 16'h4014;
                    bus.cpu_rw   = 1'b0;
                    bus.cpu_dout = 8'h05;
                    @(posedge clk); #1;
                    bus.cpu_addr = 16'h0000;
                    bus.cpu_rw   = 1'b1;
                    bus.cpu_dout = 8'h00;
                    @(posedge clk); #1;
                    chk("retrig_next_rd", bus.bus_addr, {pg, 8'(retrigIdx + 1)});
                    retrigIdx = -1;
                end else if (rstIdx >= 0 && bus.bus_addr == {pg, 8'(rstIdx)}) begin
                    #1 DMA_RST = 1'b1;
                    #1 checkResetValues("midrst");
                    bus.dma_gnt = 1'b0;
                    @(posedge clk); #1;
                    DMA_RST = 1'b0;
                    done = 1;
                end
            end
        end
        chk("xfer_finished", done, 1'b1);
        bus.dma_gnt = 1'b0;
    endtask

    initial begin
        DMA_RST      = 1'b1;
        bus.cpu_addr = 16'h0000;
        bus.cpu_rw   = 1'b1;
        bus.cpu_dout = 8'h00;
        bus.dma_gnt  = 1'b0;
        repeat (2) @(posedge clk);
        #1 checkResetValues("reset");
        DMA_RST = 1'b0;

        doXfer(8'h02, 1'b0, -1, -1, -1, 0);
        chk("span_even", lastSpan, 513);
        doXfer(8'h02, 1'b1, -1, -1, -1, 0);
        chk("span_odd", lastSpan, 514);
        doXfer(8'h02, 1'b1, -1, 10, -1, 0);
        chk("span_retrig", lastSpan, 514);
        doXfer(8'h02, 1'b0, 8'h40, -1, -1, 4);
        chk("span_pause", lastSpan, 517);
        doXfer(8'h31, 1'b0, -1, -1, 100, 0);
        doXfer(8'h7C, 1'b0, -1, -1, -1, 0);
        chk("span_after_reset", lastSpan, 513);

        repeat (2) @(posedge clk);
        #1;
        chk("idle_by", bus.dma_by, 8'hFF);
        chk("idle_bflg", bus.dma_bflg, 1'b1);
        chk("idle_own", bus.bus_own, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cpu_oam_dma_ctrl.md
# cpu_oam_dma_ctrl

Sprite (OAM) DMA controller for the NES CPU. A CPU write to the DMA register ($4014) latches a source page and raises a DMA request toward the CU. Once the CU grants the bus, the controller performs 256 read/write pairs: it reads `{page, idx}` and writes the byte to the PPU OAM data port ($2004). It sits beside the CU, drives `dma_bflg`/`dma_by` into the CU interface, and owns the system bus while granted.

## Interface
Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers a DMA.
- OAM_DATA_ADDR, 16'h2004, destination address for every write cycle.

Ports:
- DMA_phi2  in  1  system clock; all state updates on the rising edge.
- DMA_RST  in  1  reset, asynchronous, active-high.
- cpu_addr  in  16  CPU address bus.
- cpu_rw  in  1  CPU read/write; 1 = read, 0 = write.
- cpu_dout  in  8  CPU write data.
- dma_gnt  in  1  high while the CU is in DMA0/DMA1, meaning the bus is granted.
- bus_din  in  8  bus read data, valid at the end of a read cycle.
- dma_bflg  out  1  DMA request to the CU, active-low.
- dma_by  out  8  remaining-byte index to the CU; 0 during the last write.
- bus_own  out  1  1 = the controller drives bus_addr, bus_rw and bus_dout.
- bus_addr  out  16  DMA bus address.
- bus_rw  out  1  DMA read/write; 1 = read.
- bus_dout  out  8  DMA write data.

## Operation
- Reset values:
  - dma_bflg = 1, dma_by = 8'hFF, bus_own = 0, bus_addr = 0, bus_rw = 1, bus_dout = 0.
  - page = 0, idx = 0, cyc_odd = 0, state = IDLE.
- cyc_odd: a free-running parity bit that toggles every clock after reset.
- Trigger: `cpu_addr == DMA_REG_ADDR` and `cpu_rw == 0` while in IDLE.
  - Latch page <= cpu_dout, idx <= 0, go to REQ.
  - A trigger in any other state is ignored; page is not overwritten.
- States:
  - IDLE: dma_bflg = 1, bus_own = 0.
  - REQ: dma_bflg = 0. Wait for dma_gnt, then go to HALT. The controller waits indefinitely.
  - HALT: one dummy cycle with bus_own = 0.
    - cyc_odd = 1 in this cycle -> ALIGN.
    - Otherwise -> RD.
  - ALIGN: one extra dummy cycle with bus_own = 0, then -> RD.
  - RD: bus_own = 1, bus_rw = 1, bus_addr = {page, idx}. Capture bus_din into a data register at the end of the cycle, then -> WR.
  - WR: bus_own = 1, bus_rw = 0, bus_addr = OAM_DATA_ADDR, bus_dout = captured byte.
    - idx == 8'hFF -> DONE.
    - Otherwise idx <= idx + 1, -> RD.
  - DONE: one cycle with bus_own = 0 and dma_bflg = 1, then -> IDLE.
  - PAUSE: entered if dma_gnt drops in HALT, ALIGN, RD or WR.
    - bus_own = 0; idx and the data register are held.
    - Return to the interrupted state when dma_gnt rises again. An interrupted RD is re-executed.
    - dma_bflg stays 0 throughout.
- Arithmetic:
  - dma_by = 8'hFF − idx, combinational from idx.
  - idx is 8-bit and never wraps within a transfer; the transfer ends at 255.
- dma_bflg is 0 from REQ until DONE inclusive of PAUSE, and 1 in DONE and IDLE.
- Reset mid-transfer: immediately return to reset values. The partial transfer is abandoned and bus_own drops asynchronously.

## Timing
- Trigger write sampled at edge N -> dma_bflg = 0 after edge N (state REQ).
- First cycle with dma_gnt = 1 is HALT. RD of byte 0 starts 1 cycle later (even parity) or 2 cycles later (odd parity).
- Each byte costs 2 cycles. Total granted span from HALT to the last WR is 513 cycles (even) or 514 cycles (odd).
- dma_by = 0 holds during the final RD/WR pair. The CU sees it in DMA1 and releases the bus, while DONE raises dma_bflg.
- All outputs are registered except dma_by, which is combinational.

## Test plan
- Reset with page = 8'h02, HALT on even parity:
  - Stimulus: after reset, CPU writes 8'h02 to $4014; grant arrives in the next cycle; HALT falls on even parity.
  - Response: 256 reads $0200..$02FF, each followed by a write to $2004 with the identical byte. Exactly 513 granted cycles. dma_bflg returns to 1.
- Odd parity: the same transfer with HALT falling on cyc_odd = 1 inserts exactly one ALIGN cycle; total 514 cycles, data unchanged.
- Retrigger mid-transfer: a write of 8'h05 to $4014 at byte 10 is ignored. Reads continue at $020B, and page stays 8'h02 to the end.
- Grant dropped mid-transfer:
  - Stimulus: dma_gnt falls for 3 cycles during the RD of idx = 8'h40.
  - Response: bus_own = 0 for those 3 cycles, then the RD of $0240 is re-executed. No byte is skipped or duplicated at $2004.
- Reset mid-transfer: DMA_RST pulses at byte 100. Outputs immediately take their reset values, and the next $4014 write starts a fresh transfer at idx = 0.
- dma_by tracking: dma_by reads 8'hFF during byte 0, 8'h00 during byte 255, and 8'hFF again in IDLE.
